// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one 256x16 synchronous RAM between the CPU memory port (port 0)
//   and the loader/DMA port (port 1). Round-robin arbitration in IDLE, a
//   fixed three-cycle access (IDLE -> ACCESS -> RESP), and a one-cycle ack.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner's request
// ACCESS | latched address/data driven to the RAM, write strobe if allowed
// RESP   | RAM read data valid; ack and rdata returned to the owner
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   pN_cmd/addr/wdata          requester command (01 read, 10 write, else none)
//   pN_rdata/ack               response data and one-cycle completion pulse
//   grant                      one-hot owner during ACCESS/RESP, 0 in IDLE
//   ram_addr/write/din/dout    RAM side; ram_dout is registered by the RAM
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    p0_cmd,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  input  logic [1:0]    p1_cmd,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic [1:0]    grant,
  output logic [AW-2:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          last;
  logic          lat_port;
  logic          lat_wr;
  logic          lat_hi;
  logic [AW-2:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic act0, act1, win, start, rd_ok;

  // 2'b11 is deliberately not an active command.
  assign act0 = (p0_cmd == 2'b01) || (p0_cmd == 2'b10);
  assign act1 = (p1_cmd == 2'b01) || (p1_cmd == 2'b10);

  // On a tie the port that did not win last time goes next.
  assign win = (act0 && act1) ? ~last : act1;

  // Only a RAM read returns data; writes and non-RAM reads return zero.
  assign rd_ok = !lat_wr && !lat_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= 1'b1;
      lat_port  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_hi    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      last      <= win;
      lat_port  <= win;
      lat_wr    <= win ? (p1_cmd == 2'b10) : (p0_cmd == 2'b10);
      lat_hi    <= win ? p1_addr[AW-1] : p0_addr[AW-1];
      lat_addr  <= win ? p1_addr[AW-2:0] : p0_addr[AW-2:0];
      lat_wdata <= win ? p1_wdata : p0_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    grant     = 2'b00;
    ram_write = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    case (state)
      IDLE: begin
        if (act0 || act1) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        grant     = lat_port ? 2'b10 : 2'b01;
        ram_write = lat_wr && !lat_hi;
      end
      RESP: begin
        state_nxt = IDLE;
        grant     = lat_port ? 2'b10 : 2'b01;
        if (lat_port) begin
          p1_ack   = 1'b1;
          p1_rdata = rd_ok ? ram_dout : '0;
        end else begin
          p0_ack   = 1'b1;
          p0_rdata = rd_ok ? ram_dout : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latches are cleared on reset, so these read as zero out of reset.
  assign ram_addr = lat_addr;
  assign ram_din  = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural 256x16 registered-read
//   RAM. A vector table covers single-port reads/writes, non-RAM addresses,
//   ties and the 2'b11 command; hand sequences cover reset during an access
//   and requester inputs changing while an access is in flight.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  p0_cmd, p1_cmd;
  logic [8:0]  p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic [1:0]  grant;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .grant(grant), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  c0;
    logic [8:0]  a0;
    logic [15:0] w0;
    logic [1:0]  c1;
    logic [8:0]  a1;
    logic [15:0] w1;
    logic [1:0]  eg;
    logic        ewr;
    logic [7:0]  eaddr;
    logic [15:0] edin;
    logic [15:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] w0,
                              input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] w1,
                              input logic [1:0] eg, input logic ewr, input logic [7:0] eaddr,
                              input logic [15:0] edin, input logic [15:0] erd);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.w0 = w0;
    v.c1 = c1; v.a1 = a1; v.w1 = w1;
    v.eg = eg; v.ewr = ewr; v.eaddr = eaddr; v.edin = edin; v.erd = erd;
    return v;
  endfunction

  task automatic idle_inputs();
    p0_cmd = 2'b00; p0_addr = '0; p0_wdata = '0;
    p1_cmd = 2'b00; p1_addr = '0; p1_wdata = '0;
  endtask

  // Called just after a rising edge with the arbiter in IDLE; returns the
  // same way, three cycles later.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    p0_cmd = v.c0; p0_addr = v.a0; p0_wdata = v.w0;
    p1_cmd = v.c1; p1_addr = v.a1; p1_wdata = v.w1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " access grant"}, 32'(grant), 32'(v.eg));
    chk({tag, " access ram_write"}, 32'(ram_write), 32'(v.ewr));
    chk({tag, " access acks"}, 32'({p1_ack, p0_ack}), 32'd0);
    if (v.ewr) begin
      chk({tag, " ram_addr"}, 32'(ram_addr), 32'(v.eaddr));
      chk({tag, " ram_din"}, 32'(ram_din), 32'(v.edin));
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " resp grant"}, 32'(grant), 32'(v.eg));
    chk({tag, " resp ram_write"}, 32'(ram_write), 32'd0);
    chk({tag, " p0_ack"}, 32'(p0_ack), 32'(v.eg[0]));
    chk({tag, " p1_ack"}, 32'(p1_ack), 32'(v.eg[1]));
    if (v.eg[1]) begin
      chk({tag, " p1_rdata"}, 32'(p1_rdata), 32'(v.erd));
      chk({tag, " p0_rdata loser"}, 32'(p0_rdata), 32'd0);
    end else begin
      chk({tag, " p0_rdata"}, 32'(p0_rdata), 32'(v.erd));
      chk({tag, " p1_rdata loser"}, 32'(p1_rdata), 32'd0);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    chk({tag, " idle grant"}, 32'(grant), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h5A5A;
    mem[8'h05] = 16'hABCD;
    mem[8'h20] = 16'h7777;

    //               c0     a0      w0        c1     a1      w1        eg     wr    addr   din       rd
    vecs[0]  = mk(2'b01, 9'h005, 16'h0000, 2'b00, 9'h000, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'hABCD);
    vecs[1]  = mk(2'b00, 9'h000, 16'h0000, 2'b10, 9'h010, 16'h1234, 2'b10, 1'b1, 8'h10, 16'h1234, 16'h0000);
    vecs[2]  = mk(2'b00, 9'h000, 16'h0000, 2'b01, 9'h010, 16'h0000, 2'b10, 1'b0, 8'h00, 16'h0000, 16'h1234);
    vecs[3]  = mk(2'b10, 9'h100, 16'hFFFF, 2'b00, 9'h000, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'h0000);
    vecs[4]  = mk(2'b01, 9'h000, 16'h0000, 2'b00, 9'h000, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'h5A5A);
    vecs[5]  = mk(2'b01, 9'h105, 16'h0000, 2'b00, 9'h000, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'h0000);
    // ties: last winner was port 0, so port 1 goes first
    vecs[6]  = mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h020, 16'h0000, 2'b10, 1'b0, 8'h00, 16'h0000, 16'h7777);
    vecs[7]  = mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h020, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'hABCD);
    vecs[8]  = mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h020, 16'h0000, 2'b10, 1'b0, 8'h00, 16'h0000, 16'h7777);
    vecs[9]  = mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h020, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'hABCD);
    // 2'b11 on port 0 is not a request
    vecs[10] = mk(2'b11, 9'h005, 16'h0000, 2'b01, 9'h010, 16'h0000, 2'b10, 1'b0, 8'h00, 16'h0000, 16'h1234);

    reset = 1'b1;
    idle_inputs();
    #2;
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst ram_write", 32'(ram_write), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_din", 32'(ram_din), 32'd0);
    chk("rst acks", 32'({p1_ack, p0_ack}), 32'd0);
    chk("rst rdata", {p1_rdata, p0_rdata}, 32'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset asserted mid-cycle during a granted write.
    p1_cmd = 2'b10; p1_addr = 9'h020; p1_wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    chk("abort pre ram_write", 32'(ram_write), 32'd1);
    chk("abort pre grant", 32'(grant), 32'b10);
    #2;
    reset = 1'b1;
    #1;
    chk("abort ram_write", 32'(ram_write), 32'd0);
    chk("abort grant", 32'(grant), 32'd0);
    chk("abort ram_addr", 32'(ram_addr), 32'd0);
    chk("abort p1_ack", 32'(p1_ack), 32'd0);
    @(posedge clk);
    #1;
    chk("abort held p1_ack", 32'(p1_ack), 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // RAM[0x20] must be untouched, and port 0 wins the first tie after reset.
    run_vec(11, mk(2'b01, 9'h020, 16'h0000, 2'b01, 9'h020, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'h7777));
    run_vec(12, mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h010, 16'h0000, 2'b10, 1'b0, 8'h00, 16'h0000, 16'h1234));
    run_vec(13, mk(2'b01, 9'h005, 16'h0000, 2'b01, 9'h010, 16'h0000, 2'b01, 1'b0, 8'h00, 16'h0000, 16'hABCD));

    // Requester address changes after the grant edge; the latched one is used.
    p0_cmd = 2'b01; p0_addr = 9'h005;
    @(posedge clk);
    #1;
    p0_addr = 9'h020;
    p0_cmd  = 2'b10;
    p0_wdata = 16'h9999;
    @(negedge clk);
    chk("hold grant", 32'(grant), 32'b01);
    chk("hold ram_write", 32'(ram_write), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold p0_ack", 32'(p0_ack), 32'd1);
    chk("hold p0_rdata", 32'(p0_rdata), 32'hABCD);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("hold ram untouched", 32'(mem[8'h20]), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
